// File: rtl/uart_tx_feeder.sv
// Byte FIFO in front of a UART transmitter: buffers system-side writes and
// launches them one at a time through the transmitter's start/ready handshake.
module uart_tx_feeder #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_wr,
    input  logic [7:0]            i_wdata,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_overflow,
    input  logic                  i_tx_ready,
    output logic                  o_tx_start,
    output logic [7:0]            o_tx_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  start_next;
    state_t                state;
    state_t                state_next;

    // Full is judged on the registered count, so a pop in the same cycle
    // never rescues a write made while full.
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign push    = i_wr && !full;
    assign o_full  = full;
    assign o_empty = empty;
    assign o_count = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (i_wr && full) begin
                o_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            o_tx_start <= 1'b0;
            o_tx_data  <= 8'h00;
        end else begin
            state      <= state_next;
            o_tx_start <= start_next;
            if (pop) begin
                o_tx_data <= mem[rd_ptr];
            end
        end
    end

    // WAIT_BUSY exists because the transmitter's ready is registered and may
    // still read high in the cycle after it accepts a start.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        start_next = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && i_tx_ready) begin
                    pop        = 1'b1;
                    start_next = 1'b1;
                    state_next = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (!i_tx_ready) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (i_tx_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: a transmitter model drives ready, and a
// scoreboard queue holds the bytes expected at each launch pulse.
module tb_uart_tx_feeder;

    logic       clk;
    logic       rstn;
    logic       i_wr;
    logic [7:0] i_wdata;
    logic       o_full;
    logic       o_empty;
    logic [4:0] o_count;
    logic       o_overflow;
    logic       i_tx_ready;
    logic       o_tx_start;
    logic [7:0] o_tx_data;

    logic       model_rdy;
    logic       hold_low;
    int         phase;
    int         busy_cnt;
    int         busy_len;
    int         total;
    int         bad;
    int         start_cnt;
    logic       prev_start;
    logic [7:0] sb[$];

    uart_tx_feeder #(.DEPTH_LOG2(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_wr       (i_wr),
        .i_wdata    (i_wdata),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_count    (o_count),
        .o_overflow (o_overflow),
        .i_tx_ready (i_tx_ready),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign i_tx_ready = model_rdy & ~hold_low;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transmitter model: ready lingers high one cycle after start, then low busy_len cycles.
    always @(negedge clk) begin
        if (!rstn) begin
            phase     = 0;
            model_rdy = 1'b1;
        end else if (phase == 0 && o_tx_start) begin
            phase = 1;
        end else if (phase == 1) begin
            model_rdy = 1'b0;
            busy_cnt  = busy_len;
            phase     = 2;
        end else if (phase == 2) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                model_rdy = 1'b1;
                phase     = 0;
            end
        end
    end

    // Monitor: every launch pops the scoreboard and compares the byte.
    always @(negedge clk) begin
        if (rstn) begin
            if (o_tx_start) begin
                start_cnt++;
                total++;
                if (prev_start) begin
                    bad++;
                    $display("FAIL start_twice: got two consecutive start cycles at %0t", $time);
                end
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL launch_unexpected: got data %0h expected no launch at %0t", o_tx_data, $time);
                end else begin
                    logic [7:0] exp_b;
                    exp_b = sb.pop_front();
                    if (o_tx_data !== exp_b) begin
                        bad++;
                        $display("FAIL launch_data: got %0h expected %0h at %0t", o_tx_data, exp_b, $time);
                    end
                end
            end
        end
        prev_start = o_tx_start;
    end

    task automatic wr(input logic [7:0] d, input bit accept);
        i_wr    = 1'b1;
        i_wdata = d;
        if (accept) sb.push_back(d);
        @(posedge clk);
        #1;
        i_wr = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (!(o_empty && sb.size() == 0 && phase == 0 && i_tx_ready) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_drain_timeout"}, (n < 2000), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int s0;
        total      = 0;
        bad        = 0;
        start_cnt  = 0;
        prev_start = 1'b0;
        phase      = 0;
        busy_cnt   = 0;
        busy_len   = 3;
        model_rdy  = 1'b1;
        hold_low   = 1'b0;
        i_wr       = 1'b0;
        i_wdata    = 8'h00;
        rstn       = 1'b0;
        #2;
        chk("rst_empty", o_empty, 1);
        chk("rst_full", o_full, 0);
        chk("rst_count", o_count, 0);
        chk("rst_overflow", o_overflow, 0);
        chk("rst_start", o_tx_start, 0);
        chk("rst_data", o_tx_data, 8'h00);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single byte with two-cycle launch latency
        wr(8'hA5, 1);
        chk("single_empty", o_empty, 0);
        chk("single_count", o_count, 1);
        chk("single_start_early", o_tx_start, 0);
        @(posedge clk);
        #1;
        chk("single_start", o_tx_start, 1);
        chk("single_data", o_tx_data, 8'hA5);
        chk("single_empty_after", o_empty, 1);
        wait_drain("single");

        // Burst of 16 with the transmitter held off, then overflow
        hold_low = 1'b1;
        for (int i = 1; i <= 16; i++) wr(8'(i), 1);
        chk("burst_full", o_full, 1);
        chk("burst_count", o_count, 16);
        chk("burst_overflow", o_overflow, 0);
        wr(8'hEE, 0);
        chk("ovf_flag", o_overflow, 1);
        chk("ovf_count", o_count, 16);

        // Push while full in the same cycle as a pop: push dropped, pop done
        hold_low = 1'b0;
        i_wr     = 1'b1;
        i_wdata  = 8'hEF;
        @(posedge clk);
        #1;
        i_wr = 1'b0;
        chk("full_pushpop_count", o_count, 15);
        chk("full_pushpop_start", o_tx_start, 1);
        chk("full_pushpop_data", o_tx_data, 8'h01);
        wait_drain("burst");
        chk("burst_drained_empty", o_empty, 1);
        chk("ovf_sticky", o_overflow, 1);

        // Push and pop together at count 1
        hold_low = 1'b1;
        wr(8'h33, 1);
        chk("c1_count_before", o_count, 1);
        hold_low = 1'b0;
        sb.push_back(8'h44);
        i_wr     = 1'b1;
        i_wdata  = 8'h44;
        @(posedge clk);
        #1;
        i_wr = 1'b0;
        chk("c1_count_after", o_count, 1);
        chk("c1_data", o_tx_data, 8'h33);
        wait_drain("count1");

        // Ready lingers then stays low for 20 cycles
        busy_len = 20;
        s0 = start_cnt;
        wr(8'h55, 1);
        wr(8'h66, 1);
        repeat (19) @(posedge clk);
        #1;
        chk("linger_one_start", start_cnt - s0, 1);
        chk("linger_count", o_count, 1);
        wait_drain("linger");
        chk("linger_two_starts", start_cnt - s0, 2);

        // Reset with five bytes queued and a transfer in WAIT_DONE
        for (int i = 0; i < 6; i++) wr(8'hB0 + 8'(i), 1);
        chk("mid_count", o_count, 5);
        chk("mid_ready_low", i_tx_ready, 0);
        rstn = 1'b0;
        #1;
        chk("mid_rst_empty", o_empty, 1);
        chk("mid_rst_count", o_count, 0);
        chk("mid_rst_full", o_full, 0);
        chk("mid_rst_overflow", o_overflow, 0);
        chk("mid_rst_start", o_tx_start, 0);
        chk("mid_rst_data", o_tx_data, 8'h00);
        sb.delete();
        @(posedge clk);
        #1;
        rstn     = 1'b1;
        busy_len = 3;
        s0       = start_cnt;
        repeat (30) @(posedge clk);
        #1;
        chk("mid_no_launch", start_cnt - s0, 0);
        wr(8'h77, 1);
        wait_drain("post_reset");
        chk("post_reset_launch", start_cnt - s0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
